// File: rtl/display_clk_gen.sv
// Board-clock divider for the seven-segment display: a 1 Hz-class data clock with
// run/pause and single-step control, a free-running scan clock, and rising-edge ticks.
module display_clk_gen #(
  parameter int CLK_HZ  = 50000000,
  parameter int SEC_HZ  = 1,
  parameter int SCAN_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic step,
  output logic clk_sec,
  output logic clk_10,
  output logic sec_tick,
  output logic scan_tick
);

  localparam int HALF_SEC  = CLK_HZ / (2 * SEC_HZ);
  localparam int HALF_SCAN = CLK_HZ / (2 * SCAN_HZ);
  localparam int SEC_W     = (HALF_SEC  > 1) ? $clog2(HALF_SEC)  : 1;
  localparam int SCAN_W    = (HALF_SCAN > 1) ? $clog2(HALF_SCAN) : 1;
  // sec_cnt doubles as the step-phase counter, so it must also hold HALF_SCAN-1.
  localparam int CNT_W     = (SEC_W > SCAN_W) ? SEC_W : SCAN_W;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(HALF_SCAN - 1);
  localparam logic [CNT_W-1:0]  SEC_LAST  = CNT_W'(HALF_SEC - 1);
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(HALF_SCAN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP_HI = 2'd1,
    STEP_LO = 2'd2
  } state_t;

  state_t             state;
  logic               en_m, en_s;
  logic               step_m, step_s, step_d;
  logic               step_rise;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [CNT_W-1:0]   sec_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_m   <= 1'b0;
      en_s   <= 1'b0;
      step_m <= 1'b0;
      step_s <= 1'b0;
      step_d <= 1'b0;
    end else begin
      en_m   <= en;
      en_s   <= en_m;
      step_m <= step;
      step_s <= step_m;
      step_d <= step_s;
    end
  end

  assign step_rise = step_s & ~step_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      clk_10    <= 1'b0;
      scan_tick <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      clk_10    <= ~clk_10;
      scan_tick <= ~clk_10;
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
      scan_tick <= 1'b0;
    end
  end

  // A pause freezes the phase mid-count; a step only starts from a low clk_sec.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sec_cnt  <= '0;
      clk_sec  <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (step_rise && !en_s && !clk_sec) begin
            state    <= STEP_HI;
            sec_cnt  <= '0;
            clk_sec  <= 1'b1;
            sec_tick <= 1'b1;
          end else if (en_s) begin
            if (sec_cnt == SEC_LAST) begin
              sec_cnt  <= '0;
              clk_sec  <= ~clk_sec;
              sec_tick <= ~clk_sec;
            end else begin
              sec_cnt <= sec_cnt + CNT_W'(1);
            end
          end
        end
        STEP_HI: begin
          if (sec_cnt == STEP_LAST) begin
            sec_cnt <= '0;
            clk_sec <= 1'b0;
            state   <= STEP_LO;
          end else begin
            sec_cnt <= sec_cnt + CNT_W'(1);
          end
        end
        STEP_LO: begin
          if (sec_cnt == STEP_LAST) begin
            sec_cnt <= '0;
            state   <= IDLE;
          end else begin
            sec_cnt <= sec_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          sec_cnt <= '0;
          clk_sec <= 1'b0;
        end
      endcase
    end
  end

endmodule
